// File: rtl/multicycle_cu.sv
// Multicycle control sequencer for the RV32I-subset core (FETCH/DECODE/MEM/EXEC/WB).
// Optional memory handshake: define MCCU_MEM_WAIT_EN to add mem_ready stalls.
module multicycle_cu #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MCCU_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pcupd;
    logic       branch;
    logic       adrsrc;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   hold;
  logic   opcode_ok;
  logic   cond;

  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupd = 1'b1;
      end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    c.regwrite = 1'b1;
      BRANCH:   begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupd = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    opcode_ok = 1'b1;
    case (opcode)
      OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: opcode_ok = 1'b1;
      default:                                 opcode_ok = 1'b0;
    endcase
  end

`ifdef MCCU_MEM_WAIT_EN
  assign hold = ~mem_ready & ((state_q == FETCH) | (state_q == MEMREAD) | (state_q == MEMWRITE));
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
    if (hold) state_d = state_q;
    ctrl_d = moore_ctrl(state_d);
  end

  // Moore outputs are registered from the next state, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= state_t'(RESET_STATE);
      ctrl_q  <= moore_ctrl(state_t'(RESET_STATE));
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    cond = 1'b0;
    case ({funct3[2], funct3[0]})
      2'b00:   cond = zero;
      2'b01:   cond = ~zero;
      2'b10:   cond = sign;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (ctrl_q.aluop)
      2'b01: ALUControl = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100)
                          ? 3'b010 : 3'b000;
      2'b10: ALUControl = (funct3 == 3'b000 && opcode[5] && funct7) ? 3'b010 : funct3;
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite   = rst_n & (ctrl_q.pcupd | (ctrl_q.branch & cond));
  assign IRWrite   = rst_n & ctrl_q.irwrite;
  assign MemWrite  = rst_n & ctrl_q.memwrite;
  assign RegWrite  = rst_n & ctrl_q.regwrite;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign ResultSrc = ctrl_q.resultsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  // The opcode only becomes valid in DECODE (IR loads at the end of FETCH), so this flag is decoded live.
  assign illegal_op = rst_n & (state_q == DECODE) & ~opcode_ok;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: directed + random instruction stream vs. a table model.
module tb_multicycle_cu;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7, zero, sign;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  logic [16:0] obs;
  int total = 0;
  int bad   = 0;

  multicycle_cu #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MCCU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero), .sign(sign),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, illegal_op};

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // Expected control bundle for one cycle, from the per-state output table and the instruction fields.
  function automatic logic [16:0] ref_vec(input logic [3:0] st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic s);
    logic pcw, adr, ir, mw, rw, ill, taken;
    logic [1:0] rs, asa, asb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; ir = 0; mw = 0; rw = 0; ill = 0;
    rs = 0; asa = 0; asb = 0; alu = 3'b000;
    case (f3)
      3'd0, 3'd2: taken = z;
      3'd1, 3'd3: taken = ~z;
      3'd4, 3'd6: taken = s;
      default:    taken = 1'b0;
    endcase
    case (st)
      4'd0:  begin pcw = 1; ir = 1; asb = 2; rs = 2; end
      4'd1:  begin asa = 1; asb = 1; ill = !is_legal(op); end
      4'd2:  begin asa = 2; asb = 1; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6, 4'd7: begin
        asa = 2; asb = (st == 4'd7) ? 2'd1 : 2'd0;
        alu = (op == 7'b0110011 && f3 == 3'd0 && f7) ? 3'b010 : f3;
      end
      4'd8:  rw = 1;
      4'd9:  begin asa = 2; alu = (f3 == 0 || f3 == 1 || f3 == 4) ? 3'b010 : 3'b000; pcw = taken; end
      4'd10: begin asa = 1; asb = 2; pcw = 1; end
      default: ;
    endcase
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    return {pcw, adr, ir, mw, rw, rs, asa, asb, alu, imm, ill};
  endfunction

  task automatic test_reset();
    rst_n = 0; mem_ready = 1; opcode = 7'b0110011; funct3 = 0; funct7 = 0; zero = 1; sign = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    total++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      bad++; $display("FAIL reset_we got=%b want=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    total++;
    if ({state_o, IRWrite, PCWrite} !== {4'd0, 2'b11}) begin
      bad++; $display("FAIL release_fetch got st=%0d ir=%b pc=%b want st=0 ir=1 pc=1",
                      state_o, IRWrite, PCWrite);
    end
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  // Directed instructions first (lw, beq taken/not, sub, addi, illegal), then random ones.
  task automatic test_instr_stream();
    logic [3:0] seq[$];
    logic [6:0] dop[6] = '{7'b0000011, 7'b1100011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b1111111};
    logic       dz[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0] legal[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    logic [16:0] exp;
    for (int n = 0; n < 66; n++) begin
      if (n < 6) begin
        opcode = dop[n]; funct3 = 3'd0; funct7 = 1'b1; zero = dz[n]; sign = 1'b0;
      end else begin
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 6) opcode = legal[r];
        else begin
          opcode = 7'($urandom);
          if (r == 6 && is_legal(opcode)) opcode = 7'b1111111;
        end
        funct3 = 3'($urandom); funct7 = 1'($urandom); zero = 1'($urandom); sign = 1'($urandom);
      end
      seq.delete();
      seq.push_back(4'd0); seq.push_back(4'd1);
      case (opcode)
        7'b0000011: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
        7'b0100011: begin seq.push_back(4'd2); seq.push_back(4'd5); end
        7'b0110011: begin seq.push_back(4'd6); seq.push_back(4'd8); end
        7'b0010011: begin seq.push_back(4'd7); seq.push_back(4'd8); end
        7'b1100011: seq.push_back(4'd9);
        7'b1101111: begin seq.push_back(4'd10); seq.push_back(4'd8); end
        default: ;
      endcase
      foreach (seq[i]) begin
        @(negedge clk);
        exp = ref_vec(seq[i], opcode, funct3, funct7, zero, sign);
        total++;
        if (state_o !== seq[i]) begin
          bad++; $display("FAIL stream_state n=%0d op=%b step=%0d got=%0d want=%0d",
                          n, opcode, i, state_o, seq[i]);
        end
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL stream_ctrl n=%0d op=%b f3=%0d f7=%b z=%b s=%b st=%0d got=%h want=%h",
                          n, opcode, funct3, funct7, zero, sign, seq[i], obs, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_in_memwb();
    opcode = 7'b0000011; funct3 = 3'd2; funct7 = 0; zero = 0; sign = 0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 0;
    @(negedge clk);
    total++;
    if (state_o !== 4'd4) begin bad++; $display("FAIL memwb_reached got=%0d want=4", state_o); end
    total++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      bad++; $display("FAIL memwb_abort_we got=%b want=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    total++;
    if ({state_o, IRWrite} !== {4'd0, 1'b1}) begin
      bad++; $display("FAIL memwb_after_reset got st=%0d ir=%b want st=0 ir=1", state_o, IRWrite);
    end
    @(posedge clk); #1;
  endtask

`ifdef MCCU_MEM_WAIT_EN
  task automatic test_mem_wait();
    rst_n = 0; mem_ready = 1;
    @(posedge clk); #1 rst_n = 1;
    opcode = 7'b0100011; funct3 = 3'd2;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1;
      @(negedge clk);
      total++;
      if ({state_o, MemWrite} !== {4'd5, 1'b1}) begin
        bad++; $display("FAIL wait_memwrite k=%0d got st=%0d mw=%b want st=5 mw=1", k, state_o, MemWrite);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL wait_return got=%0d want=0", state_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_instr_stream();
    test_reset_in_memwb();
`ifdef MCCU_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multicycle control sequencer for the RV32I-subset core. Replaces the single-cycle control path.
- Drives a shared-memory datapath with these registers: PC, OldPC, IR, Data, ALUOut.
- One FSM steps each instruction through fetch, decode, execute, memory and writeback.
- ALU control and branch-condition encodings are unchanged from the single-cycle core, so the ALU, immediate extender and register file are reused unmodified.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH). Changed only for test builds.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  1  IR[30]
- zero  in  1  ALU zero flag
- sign  in  1  ALU sign flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- IRWrite  out  1  IR and OldPC enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU operand A: 00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  ALU operand B: 00=RD2, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 ADD, 001 SHL, 010 SUB, 100 XOR, 101 SHR, 110 OR, 111 AND
- ImmSrc  out  2  immediate type: 00=I, 01=S, 10=B, 11=J
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_o  out  4  current state, for debug

Behaviour:
- Reset:
  - rst_n low at a clock edge loads state = RESET_STATE (FETCH) and clears illegal_op.
  - While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally.
  - Reset mid-instruction aborts it; no partial write-enable may be asserted.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11-15 go to FETCH.
- Each state lasts exactly one cycle. Outputs are Moore except PCWrite.
- Any output not listed for a state is 0.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jump target into ALUOut). Next by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> FETCH, with illegal_op=1 for that one cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if opcode=0000011, otherwise MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (writes ALUOut, i.e. PC+4, to rd).
- PCWrite = PCUpdate | (Branch & cond).
  - cond is selected by {funct3[2], funct3[0]}: 00 -> zero, 01 -> ~zero, 10 -> sign, 11 -> 0.
- ImmSrc is combinational from opcode in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - everything else -> 00
- ALUControl (combinational from ALUOp, funct3, opcode[5], funct7):
  - ALUOp=00 -> ADD.
  - ALUOp=01 -> SUB when funct3 is 000, 001 or 100; ADD otherwise.
  - ALUOp=10 -> SUB when funct3=000 and opcode[5]=1 and funct7=1; otherwise ALUControl = funct3.
- Instruction latencies:
  - lw: 5 cycles
  - sw, R-type, I-type ALU, JAL: 4 cycles
  - branch: 3 cycles
  - illegal opcode: 2 cycles

Optional Feature:
- Macro: MCCU_MEM_WAIT_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state and outputs until mem_ready=1.
  - While holding, IRWrite, PCWrite and MemWrite stay asserted (memory samples them only together with ready); the state advances on the edge where mem_ready=1.
  - rst_n low overrides a pending wait.
- When not defined: the port is absent and every state takes exactly one cycle.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> state_o=0 and all write enables 0. Release -> FETCH drives IRWrite=1 and PCWrite=1 in the first cycle.
- lw (opcode 0000011): state_o sequence 0,1,2,3,4,0. RegWrite=1 only in state 4. ResultSrc=01 there. ImmSrc=00 throughout.
- beq, funct3=000:
  - zero=1 -> state_o 0,1,9,0 with PCWrite=1 in state 9 and ALUControl=010.
  - zero=0 -> PCWrite=0 in state 9.
- sub, R-type (opcode 0110011, funct3=000, funct7=1): ALUControl=010 in EXECR.
- addi (opcode 0010011, funct7=1): ALUControl=000, because opcode[5]=0.
- Illegal opcode 1111111: state_o 0,1,0, with illegal_op=1 only during the DECODE cycle. No write enable asserts.
- With MCCU_MEM_WAIT_EN, sw (opcode 0100011) and mem_ready low for 3 cycles in MEMWRITE: MemWrite stays 1 for 4 cycles, then state returns to FETCH.
- rst_n=0 during MEMWB: RegWrite is 0 in that cycle and state_o=0 on the next cycle.
